// File: rtl/signed_seq_divider.sv
// rtl/signed_seq_divider.sv - sequential restoring signed divider, 2N-bit dividend by N-bit divisor
// Fixed 2N+1 cycle latency; start/busy/done handshake with overflow and divide-by-zero flags.
module signed_seq_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CW = $clog2(2*N) + 1;
  localparam logic [CW-1:0]  LAST = CW'(2*N - 1);
  localparam logic [2*N-1:0] HALF = (2*N)'(1) << (N - 1);

  logic [1:0]     state;
  logic [CW-1:0]  count;
  logic [2*N-1:0] dvd_mag;
  logic [2*N-1:0] quo_mag;
  logic [N-1:0]   dvs_mag;
  logic [N-1:0]   prem;
  logic           neg_q;
  logic           neg_r;
  logic           dbz_r;

  logic [2*N-1:0] dvd_abs;
  logic [N-1:0]   dvs_abs;
  logic [N:0]     shifted;
  logic [N+1:0]   diff;
  logic           q_bit;
  logic [N:0]     prem_next;
  logic           q_fits;
  logic [N-1:0]   q_signed;
  logic [N-1:0]   r_signed;

  always_comb begin
    dvd_abs   = dividend[2*N-1] ? -dividend : dividend;
    dvs_abs   = divisor[N-1] ? -divisor : divisor;
    // The shifted partial remainder is N+1 bits; after a successful step it is
    // below |divisor| <= 2^(N-1), so N bits are enough to hold it between steps.
    shifted   = {prem, dvd_mag[2*N-1]};
    diff      = {1'b0, shifted} - {2'b00, dvs_mag};
    q_bit     = ~diff[N+1];
    prem_next = q_bit ? diff[N:0] : shifted;
    // A negative quotient may reach magnitude 2^(N-1); a positive one may not.
    q_fits    = neg_q ? (quo_mag <= HALF) : (quo_mag < HALF);
    q_signed  = neg_q ? -quo_mag[N-1:0] : quo_mag[N-1:0];
    r_signed  = neg_r ? -prem : prem;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      dvd_mag   <= '0;
      quo_mag   <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dbz_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_mag <= dvd_abs;
            dvs_mag <= dvs_abs;
            neg_q   <= dividend[2*N-1] ^ divisor[N-1];
            neg_r   <= dividend[2*N-1];
            quo_mag <= '0;
            prem    <= '0;
            count   <= '0;
            dbz_r   <= (divisor == '0);
            state   <= DIV;
          end
        end
        DIV: begin
          prem    <= prem_next[N-1:0];
          quo_mag <= {quo_mag[2*N-2:0], q_bit};
          dvd_mag <= dvd_mag << 1;
          count   <= count + CW'(1);
          if (count == LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          done  <= 1'b1;
          state <= IDLE;
          if (dbz_r) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b1;
            ovf       <= 1'b0;
          end else if (!q_fits) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b1;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb/tb_signed_seq_divider.sv - scoreboard bench for signed_seq_divider
// Stimulus pushes hand-computed results; a negedge monitor pops on done.
module tb_signed_seq_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dbz;

  typedef struct {
    int q;
    int r;
    int o;
    int z;
    int ref_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;

  signed_seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      check("done_one_cycle", int'(prev_done), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("quotient", int'($signed(quotient)), e.q);
        check("remainder", int'($signed(remainder)), e.r);
        check("ovf", int'(ovf), e.o);
        check("dbz", int'(dbz), e.z);
        check("latency", cyc - e.ref_cyc, 2*N + 2);
        check("busy_low_at_done", int'(busy), 0);
      end
    end
    prev_done = done;
  end

  task automatic push_exp(input int eq, input int er, input int eo, input int ez, input int rc);
    exp_t e;
    e.q = eq; e.r = er; e.o = eo; e.z = ez; e.ref_cyc = rc;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || done) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", int'(busy || done), 0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_op(input int dvd, input int dvs, input int eq, input int er,
                       input int eo, input int ez);
    wait_idle();
    start    = 1'b1;
    dividend = dvd[2*N-1:0];
    divisor  = dvs[N-1:0];
    push_exp(eq, er, eo, ez, cyc);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    wait_drain();
  endtask

  initial begin
    int r0;
    rst      = 1'b1;
    start    = 1'b1;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_dbz", int'(dbz), 0);
    start = 1'b0;
    rst   = 1'b0;

    do_op(-15, 3, -5, 0, 0, 0);
    do_op(-35, 5, -7, 0, 0, 0);
    do_op(28, 7, 4, 0, 0, 0);
    do_op(23, -4, -5, 3, 0, 0);
    do_op(-23, 4, -5, -3, 0, 0);
    do_op(-23, -4, 5, -3, 0, 0);
    do_op(64, -8, -8, 0, 0, 0);
    do_op(-60, 7, -8, -4, 0, 0);
    do_op(56, 7, 0, 0, 1, 0);
    do_op(-64, -8, 0, 0, 1, 0);
    do_op(-128, -1, 0, 0, 1, 0);
    do_op(-128, -8, 0, 0, 1, 0);
    do_op(127, 7, 0, 0, 1, 0);
    do_op(10, 0, 0, 0, 0, 1);

    // Start pulse during an operation must be ignored.
    wait_idle();
    start = 1'b1; dividend = 8'd28; divisor = 4'd7;
    push_exp(4, 0, 0, 0, cyc);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'(-15); divisor = 4'd3;
    @(negedge clk); start = 1'b0;
    wait_drain();

    // Start held high: one result every 2N+2 cycles.
    wait_idle();
    r0 = cyc;
    start = 1'b1; dividend = 8'd10; divisor = 4'd0;
    push_exp(0, 0, 0, 1, r0);
    @(negedge clk);
    dividend = 8'(-35); divisor = 4'd5;
    push_exp(-7, 0, 0, 0, r0 + 2*N + 2);
    repeat (2*N + 2) @(negedge clk);
    dividend = 8'd23; divisor = 4'(-4);
    push_exp(-5, 3, 0, 0, r0 + 2*(2*N + 2));
    repeat (2*N + 2) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Reset after DIV step 4 aborts the operation with no done.
    wait_idle();
    start = 1'b1; dividend = 8'(-23); divisor = 4'd4;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_quotient", int'(quotient), 0);
    check("abort_remainder", int'(remainder), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_ovf", int'(ovf), 0);
    check("abort_dbz", int'(dbz), 0);
    repeat (3*N) @(negedge clk);
    do_op(-15, 3, -5, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/signed_seq_divider.md
# signed_seq_divider

Sequential signed divider complementing the team's Booth multiplier: it accepts a 2N-bit signed dividend and an N-bit signed divisor on a `start` strobe. It returns an N-bit signed quotient and an N-bit signed remainder after a fixed 2N+1-cycle latency, with overflow and divide-by-zero flags. Its operand and result widths mirror the multiplier's, so a multiplier product fed back in with one multiplier operand as the divisor recovers the other operand. One operation is in flight at a time, with a start/busy/done handshake.

## Interface
- `N`, default 4: divisor/quotient/remainder width; dividend is 2N bits.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  2N  signed dividend, captured when start accepted.
- `divisor`  in  N  signed divisor, captured when start accepted.
- `quotient`  out  N  signed quotient, truncated toward zero.
- `remainder`  out  N  signed remainder, sign of dividend (or zero).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse: results/flags valid.
- `ovf`  out  1  true quotient not representable in N signed bits.
- `dbz`  out  1  divisor was zero.

## Operation
- States: IDLE, DIV, FIX.
- IDLE: on an edge with `start`=1, the block:
  - captures operand signs and magnitudes (2N-bit |dividend|, N-bit |divisor|);
  - clears the 2N-bit quotient-magnitude register and the partial remainder;
  - sets count=0, `dbz` internal = (divisor==0);
  - moves to DIV. `busy` goes high.
- DIV: one restoring step per cycle, 2N cycles:
  - shift the partial remainder left with the next dividend MSB;
  - subtract |divisor|; if non-negative, keep the result and shift in quotient bit 1, else restore and shift in 0.
  - The partial remainder is N+1 bits wide. After step 2N-1 the block moves to FIX.
- FIX (one cycle):
  - Apply signs. The quotient is negated when the operand signs differ. The remainder is negated when the dividend is negative.
  - Range check: the signed quotient must lie in [-2^(N-1), 2^(N-1)-1]. The magnitude is checked on the full 2N-bit register, so the negative case admits 2^(N-1).
  - Register outputs, pulse `done`, drop `busy`, and return to IDLE.
- Divide by zero: iterations still run (fixed latency). The block outputs quotient=0, remainder=0, `dbz`=1, `ovf`=0.
- Overflow (divisor≠0): the block outputs quotient=0, remainder=0, `ovf`=1, `dbz`=0.
- Normal result: `ovf`=`dbz`=0; the identity dividend = quotient·divisor + remainder holds exactly, with |remainder| < |divisor|.
- Most-negative dividend (-2^(2N-1)) has magnitude 2^(2N-1), which fits the 2N-bit unsigned magnitude register. No special case.
- `start` while busy (DIV/FIX) is ignored; operands are not re-sampled.

## Timing
- Reset: state=IDLE, quotient=0, remainder=0, `busy`=0, `done`=0, `ovf`=0, `dbz`=0. `rst` overrides `start` on the same edge.
- Reset mid-operation aborts the operation: the next cycle shows the reset values, and no `done` is produced for the aborted operation.
- Accept edge E0 (IDLE, start=1): `busy`=1 from the cycle after E0.
- Edges E1..E2N: DIV steps. Edge E2N+1: FIX registers results.
- `done`=1 and `busy`=0 during the cycle after E2N+1. Latency = 2N+1 cycles from the accept edge (9 for N=4).
- `done` clears on the next edge. quotient/remainder/`ovf`/`dbz` hold until the next FIX.
- `start` held high continuously: the next operation is accepted on the edge that ends the `done` cycle, giving back-to-back throughput of one result per 2N+2 cycles.

## Test plan
- Exact division, N=4:
  - dividend=-15, divisor=3 -> quotient=-5, remainder=0, `done` exactly 9 cycles after accept.
  - dividend=-35, divisor=5 -> quotient=-7.
  - dividend=28, divisor=7 -> quotient=4.
- Remainder sign rules:
  - 23/-4 -> quotient=-5, remainder=3.
  - -23/4 -> quotient=-5, remainder=-3.
  - -23/-4 -> quotient=5, remainder=-3.
- Range boundaries:
  - -64/8 -> quotient=-8, `ovf`=0.
  - 64/8 -> `ovf`=1, quotient=0, remainder=0.
  - -128/-1 -> `ovf`=1.
  - -128/-8 -> `ovf`=1.
- Divide by zero: 10/0 -> `dbz`=1, `ovf`=0, quotient=0, remainder=0, same 9-cycle latency.
- Handshake:
  - Pulse `start` with new operands at cycle 3 of an operation -> ignored; the result matches the first operands.
  - `start` held high -> results back-to-back every 10 cycles, `done` one cycle each.
- Reset: assert `rst` at DIV step 4 -> next cycle shows all outputs 0, `busy`=0, and no `done`. A fresh start afterwards completes correctly.
